// File: rtl/seq_calc.sv
// Multi-cycle signed calculator: single-cycle add/sub/mul, W-step restoring divide/modulo,
// range check against the display limits and a busy/done handshake towards the formatter.
module seq_calc #(
    parameter int unsigned W         = 32,
    parameter longint      HI        = 1_000_000,
    parameter longint      LO        = -100_000,
    parameter logic [31:0] ERR_CODE  = 32'h00EE0000,
    parameter logic [31:0] INIT_CODE = 32'h00CC0000
) (
    input  logic         sw_clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] operand1,
    input  logic [W-1:0] operand2,
    input  logic [2:0]   operator,
    output logic         busy,
    output logic         done,
    output logic [31:0]  result,
    output logic [1:0]   err
);

    localparam int unsigned CW = $clog2(W + 1);

    localparam logic [1:0] ErrOk      = 2'd0;
    localparam logic [1:0] ErrRange   = 2'd1;
    localparam logic [1:0] ErrDivZero = 2'd2;
    localparam logic [1:0] ErrInvalid = 2'd3;

    typedef enum logic [1:0] {StIdle, StExec, StDiv, StFin} state_e;

    state_e                 state_q, state_d;
    logic [W-1:0]           a_q, a_d, b_q, b_d;
    logic [2:0]             op_q, op_d;
    logic signed [2*W-1:0]  ans_q, ans_d;
    logic [1:0]             flag_q, flag_d;
    logic [W-1:0]           dvd_q, dvd_d;
    logic [W:0]             dvs_q, dvs_d;
    logic [W-1:0]           rem_q, rem_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   busy_q, busy_d, done_q, done_d;
    logic [31:0]            result_q, result_d;
    logic [1:0]             err_q, err_d;

    logic [2*W-1:0]         a_ext, b_ext, q_mag, r_mag;
    logic [W-1:0]           a_mag, b_mag;
    logic [W:0]             trial;
    logic                   ge;
    logic signed [2*W-1:0]  fin_ans;
    logic signed [63:0]     ans_ext;
    logic                   in_range;

    assign a_ext = {{W{a_q[W-1]}}, a_q};
    assign b_ext = {{W{b_q[W-1]}}, b_q};
    // |-2^(W-1)| = 2^(W-1) still fits a W-bit unsigned magnitude
    assign a_mag = a_q[W-1] ? (~a_q + W'(1)) : a_q;
    assign b_mag = b_q[W-1] ? (~b_q + W'(1)) : b_q;

    // Quotient bits accumulate in dvd_q as the dividend shifts out of its top
    assign trial = {rem_q, dvd_q[W-1]};
    assign ge    = (trial >= dvs_q);

    assign q_mag = {{W{1'b0}}, dvd_q};
    assign r_mag = {{W{1'b0}}, rem_q};

    always_comb begin
        fin_ans = ans_q;
        if (op_q == 3'd3) begin
            fin_ans = (a_q[W-1] ^ b_q[W-1]) ? -q_mag : q_mag;
        end else if (op_q == 3'd4) begin
            fin_ans = a_q[W-1] ? -r_mag : r_mag;
        end
        ans_ext  = 64'(fin_ans);
        in_range = (ans_ext > LO) && (ans_ext < HI);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        ans_d    = ans_q;
        flag_d   = flag_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        err_d    = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = operand1;
                    b_d     = operand2;
                    op_d    = operator;
                    flag_d  = ErrOk;
                    busy_d  = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StFin;
                case (op_q)
                    3'd0: ans_d = a_ext + b_ext;
                    3'd1: ans_d = a_ext - b_ext;
                    // Low 2W bits of the sign-extended product are the signed product
                    3'd2: ans_d = a_ext * b_ext;
                    3'd3, 3'd4: begin
                        if (b_q == '0) begin
                            flag_d = ErrDivZero;
                        end else begin
                            dvd_d   = a_mag;
                            dvs_d   = {1'b0, b_mag};
                            rem_d   = '0;
                            cnt_d   = CW'(W);
                            state_d = StDiv;
                        end
                    end
                    default: flag_d = ErrInvalid;
                endcase
            end
            StDiv: begin
                rem_d = ge ? W'(trial - dvs_q) : trial[W-1:0];
                dvd_d = {dvd_q[W-2:0], ge};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
                if (flag_q != ErrOk) begin
                    result_d = ERR_CODE;
                    err_d    = flag_q;
                end else if (in_range) begin
                    result_d = ans_ext[31:0];
                    err_d    = ErrOk;
                end else begin
                    result_d = ERR_CODE;
                    err_d    = ErrRange;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            ans_q    <= '0;
            flag_q   <= ErrOk;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= INIT_CODE;
            err_q    <= ErrOk;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            ans_q    <= ans_d;
            flag_q   <= flag_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign err    = err_q;

endmodule

// File: tb/tb_seq_calc.sv
// Directed bench for seq_calc: a vector table for single operations plus hand-written
// sequences for reset, held start, ignored start and abort; a second W=8 instance.
module tb_seq_calc;

    localparam logic [31:0] ERR  = 32'h00EE0000;
    localparam logic [31:0] INIT = 32'h00CC0000;

    logic        sw_clk = 1'b0;
    logic        rst = 1'b0;
    always #5 sw_clk = ~sw_clk;

    logic        start;
    logic [31:0] operand1, operand2;
    logic [2:0]  operator;
    logic        busy, done;
    logic [31:0] result;
    logic [1:0]  err;

    logic        start8;
    logic [7:0]  a8, b8;
    logic [2:0]  op8;
    logic        busy8, done8;
    logic [31:0] result8;
    logic [1:0]  err8;

    seq_calc #(.W(32)) dut (
        .sw_clk(sw_clk), .rst(rst), .start(start), .operand1(operand1), .operand2(operand2),
        .operator(operator), .busy(busy), .done(done), .result(result), .err(err)
    );

    seq_calc #(.W(8)) dut8 (
        .sw_clk(sw_clk), .rst(rst), .start(start8), .operand1(a8), .operand2(b8),
        .operator(op8), .busy(busy8), .done(done8), .result(result8), .err(err8)
    );

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    bit sel8 = 1'b0;

    logic        cur_busy, cur_done;
    logic [31:0] cur_result;
    logic [1:0]  cur_err;
    assign cur_busy   = sel8 ? busy8 : busy;
    assign cur_done   = sel8 ? done8 : done;
    assign cur_result = sel8 ? result8 : result;
    assign cur_err    = sel8 ? err8 : err;

    always @(negedge sw_clk) if (done === 1'b1) done_cnt++;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] res;
        logic [1:0]  err;
    } vec_t;

    vec_t vecs[$];
    vec_t vecs8[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        int lat;
        lat = 0;
        @(negedge sw_clk);
        if (sel8) begin
            start8 = 1'b1; a8 = v.a[7:0]; b8 = v.b[7:0]; op8 = v.op;
        end else begin
            start = 1'b1; operand1 = v.a; operand2 = v.b; operator = v.op;
        end
        @(posedge sw_clk);
        #1;
        // Scramble inputs after acceptance: the DUT must have latched them
        if (sel8) begin
            start8 = 1'b0; a8 = ~v.a[7:0]; b8 = 8'h0; op8 = 3'd7;
        end else begin
            start = 1'b0; operand1 = ~v.a; operand2 = 32'h0; operator = 3'd7;
        end
        check({v.name, " busy"}, 32'(cur_busy), 32'd1);
        for (int k = 1; k <= 100; k++) begin
            @(posedge sw_clk);
            #1;
            if (cur_done) begin
                lat = k;
                break;
            end
        end
        check({v.name, " latency"}, 32'(lat), 32'(v.lat));
        check({v.name, " result"}, cur_result, v.res);
        check({v.name, " err"}, 32'(cur_err), 32'(v.err));
        check({v.name, " busy at done"}, 32'(cur_busy), 32'd0);
        @(posedge sw_clk);
        #1;
        check({v.name, " done pulse"}, 32'(cur_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, first, prev, ndone;

        start = 1'b0; operand1 = '0; operand2 = '0; operator = '0;
        start8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;

        vecs.push_back('{"add",       3'd0, 32'd1234,       32'(-234), 2,  32'd1000,    2'd0});
        vecs.push_back('{"mul_range", 3'd2, 32'd1000,       32'd1000,  2,  ERR,         2'd1});
        vecs.push_back('{"div",       3'd3, 32'(-7),        32'd2,     34, 32'(-3),     2'd0});
        vecs.push_back('{"mod",       3'd4, 32'(-7),        32'd2,     34, 32'(-1),     2'd0});
        vecs.push_back('{"div0",      3'd3, 32'd7,          32'd0,     2,  ERR,         2'd2});
        vecs.push_back('{"inv6",      3'd6, 32'd5,          32'd3,     2,  ERR,         2'd3});
        vecs.push_back('{"sub_lo",    3'd1, 32'(-99999),    32'd1,     2,  ERR,         2'd1});
        vecs.push_back('{"sub_ok",    3'd1, 32'(-99998),    32'd1,     2,  32'(-99999), 2'd0});
        vecs.push_back('{"div_negb",  3'd3, 32'd7,          32'(-2),   34, 32'(-3),     2'd0});
        vecs.push_back('{"mod_negb",  3'd4, 32'd7,          32'(-2),   34, 32'd1,       2'd0});
        vecs.push_back('{"div_min",   3'd3, 32'h80000000,   32'(-1),   34, ERR,         2'd1});
        vecs.push_back('{"mod_min",   3'd4, 32'h80000000,   32'd3,     34, 32'(-2),     2'd0});
        vecs.push_back('{"add_hi_ok", 3'd0, 32'd999999,     32'd0,     2,  32'd999999,  2'd0});
        vecs.push_back('{"add_hi",    3'd0, 32'd999999,     32'd1,     2,  ERR,         2'd1});
        vecs.push_back('{"mul_neg",   3'd2, 32'(-300),      32'd300,   2,  32'(-90000), 2'd0});
        vecs.push_back('{"mul_big",   3'd2, 32'h7FFFFFFF,   32'd2,     2,  ERR,         2'd1});
        vecs.push_back('{"inv7_b0",   3'd7, 32'd1,          32'd0,     2,  ERR,         2'd3});
        vecs.push_back('{"mod0",      3'd4, 32'd5,          32'd0,     2,  ERR,         2'd2});
        vecs.push_back('{"div_100_7", 3'd3, 32'd100,        32'd7,     34, 32'd14,      2'd0});
        vecs.push_back('{"mod_100_7", 3'd4, 32'd100,        32'd7,     34, 32'd2,       2'd0});
        vecs.push_back('{"div_zero",  3'd3, 32'd0,          32'd5,     34, 32'd0,       2'd0});

        vecs8.push_back('{"w8_div_min",  3'd3, 32'h80, 32'h01, 10, 32'hFFFFFF80, 2'd0});
        vecs8.push_back('{"w8_div_neg1", 3'd3, 32'h80, 32'hFF, 10, 32'h00000080, 2'd0});
        vecs8.push_back('{"w8_mod_min",  3'd4, 32'h80, 32'h03, 10, 32'hFFFFFFFE, 2'd0});
        vecs8.push_back('{"w8_mul_max",  3'd2, 32'h7F, 32'h7F, 2,  32'h00003F01, 2'd0});
        vecs8.push_back('{"w8_mul_min",  3'd2, 32'h80, 32'h80, 2,  32'h00004000, 2'd0});

        // Reset values, during and after reset
        repeat (2) @(posedge sw_clk);
        #1;
        check("in_reset result", result, INIT);
        check("in_reset busy", 32'(busy), 32'd0);
        @(negedge sw_clk);
        rst = 1'b1;
        repeat (5) @(posedge sw_clk);
        #1;
        check("idle result", result, INIT);
        check("idle err", 32'(err), 32'd0);
        check("idle busy", 32'(busy), 32'd0);
        check("idle no done", 32'(done_cnt), 32'd0);
        check("w8 idle result", result8, INIT);

        foreach (vecs[i]) run_op(vecs[i]);

        // start held high: one op per 3 cycles
        @(negedge sw_clk);
        start = 1'b1; operand1 = 32'd1; operand2 = 32'd1; operator = 3'd0;
        prev = -1;
        ndone = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge sw_clk);
            #1;
            if (done) begin
                ndone++;
                check("hold result", result, 32'd2);
                if (prev >= 0) check("hold gap", 32'(k - prev), 32'd3);
                prev = k;
            end
        end
        start = 1'b0;
        check("hold done count", 32'(ndone), 32'd6);
        repeat (5) @(posedge sw_clk);
        #1;
        check("hold idle busy", 32'(busy), 32'd0);

        // start pulsed mid-division is ignored
        d0 = done_cnt;
        @(negedge sw_clk);
        start = 1'b1; operand1 = 32'd1000; operand2 = 32'd3; operator = 3'd3;
        @(posedge sw_clk);
        #1;
        start = 1'b0;
        first = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge sw_clk);
            #1;
            if (k == 10) begin
                start = 1'b1; operator = 3'd0; operand1 = 32'd5; operand2 = 32'd5;
            end
            if (k == 11) start = 1'b0;
            if (done && first == 0) first = k;
        end
        check("midstart latency", 32'(first), 32'd34);
        check("midstart result", result, 32'd333);
        check("midstart done count", 32'(done_cnt - d0), 32'd1);
        check("midstart busy", 32'(busy), 32'd0);

        // Reset during division abandons the operation
        @(negedge sw_clk);
        start = 1'b1; operand1 = 32'd1000; operand2 = 32'd7; operator = 3'd3;
        @(posedge sw_clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge sw_clk);
        #1;
        check("abort busy before", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("abort result", result, INIT);
        check("abort err", 32'(err), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        d0 = done_cnt;
        @(negedge sw_clk);
        rst = 1'b1;
        repeat (40) @(posedge sw_clk);
        #1;
        check("abort no done", 32'(done_cnt - d0), 32'd0);
        check("abort result held", result, INIT);

        sel8 = 1'b1;
        foreach (vecs8[i]) run_op(vecs8[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
